decode_issue_scoreboard: RTL and testbench

- Parametrised decode-to-execute issue stage: a scoreboard-based load-use hazard checker plus a registered decode/execute payload stage with valid/ready handshake and flush.
- Generalises single-load, two-source hazard detection to NUM_SRC source operands and a configurable LOAD_LATENCY.
- Sits between the register-address/controller decode logic and the execute stage. Inserts bubbles on hazards and kills the held instruction on branch flush.

---
 rtl/decode_issue_scoreboard.sv | 153 +++++++++++++++
 tb/tb_decode_issue_scoreboard.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard
// Decode-to-execute issue stage: a per-register load-use scoreboard that
// stalls dependent instructions, plus a registered payload stage with
// valid/ready handshake and branch flush.
// Optional performance counters are enabled with the macro
// DECODE_ISSUE_PERF_CNT_EN; without it stall_count_o/flush_count_o are 0.
module decode_issue_scoreboard #(
    parameter int ADDR_WIDTH    = 4,
    parameter int NUM_SRC       = 3,
    parameter int PAYLOAD_WIDTH = 96,
    parameter int LOAD_LATENCY  = 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]   src_addr_i,
    input  logic [NUM_SRC-1:0]              src_used_i,
    input  logic [ADDR_WIDTH-1:0]           dest_addr_i,
    input  logic                            dest_write_en_i,
    input  logic                            is_load_i,
    input  logic [PAYLOAD_WIDTH-1:0]        payload_i,
    input  logic                            flush_i,
    input  logic                            out_ready_i,
    output logic                            out_valid_o,
    output logic [NUM_SRC*ADDR_WIDTH-1:0]   out_src_addr_o,
    output logic [ADDR_WIDTH-1:0]           out_dest_addr_o,
    output logic                            out_dest_write_en_o,
    output logic                            out_is_load_o,
    output logic [PAYLOAD_WIDTH-1:0]        out_payload_o,
    output logic                            hazard_o,
    output logic [31:0]                     stall_count_o,
    output logic [31:0]                     flush_count_o
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam int CNT_W    = (LOAD_LATENCY < 1) ? 1 : $clog2(LOAD_LATENCY + 1);

    // Output register state; write-enable and load flags are gated by valid
    // at the ports so stale fields never look live.
    logic                          valid_reg;
    logic [NUM_SRC*ADDR_WIDTH-1:0] src_reg;
    logic [ADDR_WIDTH-1:0]         dest_reg;
    logic                          dest_we_reg;
    logic                          is_load_reg;
    logic [PAYLOAD_WIDTH-1:0]      payload_reg;

    // One bit per register: a load result is still in flight.
    logic [NUM_REGS-1:0]           busy;

    logic hazard_any;
    logic stage_free;
    logic issue;
    logic load_set;
    logic flush_clear;

    // Any used source slot that names a busy register is a load-use hazard.
    always_comb begin
        hazard_any = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_used_i[k] && busy[src_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]]) begin
                hazard_any = 1'b1;
            end
        end
    end

    assign hazard_o    = in_valid_i & hazard_any;
    assign stage_free  = ~valid_reg | out_ready_i;
    assign in_ready_o  = ~hazard_o & ~flush_i & stage_free;
    assign issue       = in_valid_i & in_ready_o;
    assign load_set    = issue & is_load_i & dest_write_en_i;
    assign flush_clear = flush_i & valid_reg & is_load_reg;

    // Output register: reset, then flush, then issue, then bubble, else hold.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_reg   <= 1'b0;
            src_reg     <= '0;
            dest_reg    <= '0;
            dest_we_reg <= 1'b0;
            is_load_reg <= 1'b0;
            payload_reg <= '0;
        end else if (flush_i) begin
            valid_reg   <= 1'b0;
        end else if (issue) begin
            valid_reg   <= 1'b1;
            src_reg     <= src_addr_i;
            dest_reg    <= dest_addr_i;
            dest_we_reg <= dest_write_en_i;
            is_load_reg <= is_load_i;
            payload_reg <= payload_i;
        end else if (out_ready_i) begin
            valid_reg   <= 1'b0;
        end
    end

    assign out_valid_o         = valid_reg;
    assign out_src_addr_o      = src_reg;
    assign out_dest_addr_o     = dest_reg;
    assign out_dest_write_en_o = valid_reg & dest_we_reg;
    assign out_is_load_o       = valid_reg & is_load_reg;
    assign out_payload_o       = payload_reg;

    // Scoreboard: one down-counter per register. A new load sets it, a
    // flushed held load clears it, each downstream advance counts it down.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            logic [CNT_W-1:0] cnt_reg;

            // Per-entry counter update with set > flush-clear > decrement.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    cnt_reg <= '0;
                end else if (load_set && (dest_addr_i == ADDR_WIDTH'(gi))) begin
                    cnt_reg <= CNT_W'(LOAD_LATENCY);
                end else if (flush_clear && (dest_reg == ADDR_WIDTH'(gi))) begin
                    cnt_reg <= '0;
                end else if (out_ready_i && (cnt_reg != '0)) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end

            assign busy[gi] = (cnt_reg != '0);
        end
    endgenerate

`ifdef DECODE_ISSUE_PERF_CNT_EN
    logic [31:0] stall_count_reg;
    logic [31:0] flush_count_reg;

    // Saturating counts of hazard cycles and of flushes that killed a live instruction.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (hazard_o && (stall_count_reg != 32'hFFFF_FFFF)) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
            if (flush_i && valid_reg && (flush_count_reg != 32'hFFFF_FFFF)) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign stall_count_o = stall_count_reg;
    assign flush_count_o = flush_count_reg;
`else
    assign stall_count_o = 32'd0;
    assign flush_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// tb_decode_issue_scoreboard
// Two instances share stimulus: dut_a with LOAD_LATENCY=1 and dut_b with
// LOAD_LATENCY=3. Each scenario selects which instance it checks. Issued
// payloads are queued when driven and checked when the output stage hands
// them to execute (or discarded when a flush kills them).
// Perf-counter checks follow DECODE_ISSUE_PERF_CNT_EN.
module tb_decode_issue_scoreboard;

    localparam int AW = 4;
    localparam int NS = 3;
    localparam int PW = 96;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0]   src_used;
    logic [AW-1:0]   dest_addr;
    logic            dest_we;
    logic            is_load;
    logic [PW-1:0]   payload;
    logic            flush;
    logic            out_ready;

    logic            in_ready_a, out_valid_a, out_dwe_a, out_ld_a, hazard_a;
    logic [NS*AW-1:0] out_src_a;
    logic [AW-1:0]   out_dest_a;
    logic [PW-1:0]   out_pl_a;
    logic [31:0]     stall_a, flushc_a;

    logic            in_ready_b, out_valid_b, out_dwe_b, out_ld_b, hazard_b;
    logic [NS*AW-1:0] out_src_b;
    logic [AW-1:0]   out_dest_b;
    logic [PW-1:0]   out_pl_b;
    logic [31:0]     stall_b, flushc_b;

    int checks = 0;
    int errors = 0;
    logic sel_b = 1'b0;
    logic mon_en = 1'b0;
    logic [PW-1:0] exp_q [$];

    always #5 clk = ~clk;

    decode_issue_scoreboard #(.ADDR_WIDTH(AW), .NUM_SRC(NS), .PAYLOAD_WIDTH(PW), .LOAD_LATENCY(1)) dut_a (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
        .src_addr_i(src_addr), .src_used_i(src_used), .dest_addr_i(dest_addr),
        .dest_write_en_i(dest_we), .is_load_i(is_load), .payload_i(payload),
        .flush_i(flush), .out_ready_i(out_ready), .out_valid_o(out_valid_a),
        .out_src_addr_o(out_src_a), .out_dest_addr_o(out_dest_a),
        .out_dest_write_en_o(out_dwe_a), .out_is_load_o(out_ld_a),
        .out_payload_o(out_pl_a), .hazard_o(hazard_a),
        .stall_count_o(stall_a), .flush_count_o(flushc_a));

    decode_issue_scoreboard #(.ADDR_WIDTH(AW), .NUM_SRC(NS), .PAYLOAD_WIDTH(PW), .LOAD_LATENCY(3)) dut_b (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
        .src_addr_i(src_addr), .src_used_i(src_used), .dest_addr_i(dest_addr),
        .dest_write_en_i(dest_we), .is_load_i(is_load), .payload_i(payload),
        .flush_i(flush), .out_ready_i(out_ready), .out_valid_o(out_valid_b),
        .out_src_addr_o(out_src_b), .out_dest_addr_o(out_dest_b),
        .out_dest_write_en_o(out_dwe_b), .out_is_load_o(out_ld_b),
        .out_payload_o(out_pl_b), .hazard_o(hazard_b),
        .stall_count_o(stall_b), .flush_count_o(flushc_b));

    logic          o_valid, o_rdy, o_hz;
    logic [AW-1:0] o_dest;
    logic [PW-1:0] o_pl;
    assign o_valid = sel_b ? out_valid_b : out_valid_a;
    assign o_rdy   = sel_b ? in_ready_b  : in_ready_a;
    assign o_hz    = sel_b ? hazard_b    : hazard_a;
    assign o_dest  = sel_b ? out_dest_b  : out_dest_a;
    assign o_pl    = sel_b ? out_pl_b    : out_pl_a;

    function automatic logic [PW-1:0] pl(input logic [31:0] n);
        return {n, ~n, n ^ 32'h5A5A_5A5A};
    endfunction

    function automatic logic [NS*AW-1:0] src3(input logic [AW-1:0] s0, s1, s2);
        return {s2, s1, s0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [NS*AW-1:0] s, input logic [NS-1:0] u,
                         input logic [AW-1:0] d, input logic we, input logic ld,
                         input logic [PW-1:0] p);
        in_valid  = v;
        src_addr  = s;
        src_used  = u;
        dest_addr = d;
        dest_we   = we;
        is_load   = ld;
        payload   = p;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Output monitor: a handed-off instruction must be the oldest queued one.
    always @(negedge clk) begin
        if (mon_en && !reset && o_valid) begin
            if (flush) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL flush_kill: flushed an instruction 0x%h, none was expected", o_pl);
                end else begin
                    void'(exp_q.pop_front());
                end
            end else if (out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL handoff: got payload 0x%h, none expected", o_pl);
                end else begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    if (o_pl !== e) begin
                        errors++;
                        $display("FAIL handoff: payload 0x%h, expected 0x%h", o_pl, e);
                    end else begin
                        $display("handoff payload 0x%h dest %0d", o_pl, o_dest);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({out_valid_a, out_valid_b, out_dwe_a, out_dwe_b, out_ld_a, out_ld_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {out_valid_a, out_valid_b, out_dwe_a, out_dwe_b, out_ld_a, out_ld_b});
        end
        checks++;
        if ({hazard_a, hazard_b, in_ready_a, in_ready_b} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_handshake: got %b, expected 0011", {hazard_a, hazard_b, in_ready_a, in_ready_b});
        end
        checks++;
        if (out_pl_a !== '0 || out_dest_a !== '0 || out_src_a !== '0 || out_pl_b !== '0) begin
            errors++;
            $display("FAIL reset_fields: payload 0x%h dest %0d src 0x%h, expected 0", out_pl_a, out_dest_a, out_src_a);
        end
        checks++;
        if (stall_a !== 32'd0 || flushc_a !== 32'd0 || stall_b !== 32'd0 || flushc_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: stall %0d flush %0d, expected 0 0", stall_b, flushc_b);
        end
        $display("reset done");
    endtask

    task automatic test_load_use_lat1();
        sel_b = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, src3(4'd1, 4'd2, 4'd0), 3'b011, 4'd3, 1'b1, 1'b1, pl(10));
        #1;
        checks++;
        if (o_hz !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL lat1_load_accept: hazard %b ready %b, expected 0 1", o_hz, o_rdy);
        end
        exp_q.push_back(pl(10));
        tick();
        drive(1'b1, src3(4'd0, 4'd3, 4'd0), 3'b010, 4'd7, 1'b1, 1'b0, pl(11));
        exp_q.push_back(pl(11));
        #1;
        checks++;
        if (o_hz !== 1'b1 || o_rdy !== 1'b0 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL lat1_stall: hazard %b ready %b valid %b, expected 1 0 1", o_hz, o_rdy, o_valid);
        end
        tick();
        checks++;
        if (o_hz !== 1'b0 || o_rdy !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat1_bubble: hazard %b ready %b valid %b, expected 0 1 0", o_hz, o_rdy, o_valid);
        end
        tick();
        idle();
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_pl !== pl(11) || o_dest !== 4'd7) begin
            errors++;
            $display("FAIL lat1_dependent: valid %b payload 0x%h dest %0d, expected 1 0x%h 7", o_valid, o_pl, o_dest, pl(11));
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL lat1_drain: valid %b queued %0d, expected 0 0", o_valid, exp_q.size());
        end
        $display("lat1 load-use done");
    endtask

    task automatic test_unused_slot_and_dest();
        sel_b = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, '0, 3'b000, 4'd6, 1'b1, 1'b1, pl(20));
        exp_q.push_back(pl(20));
        tick();
        // r6 only in an unused slot and as destination: neither may stall.
        drive(1'b1, src3(4'd6, 4'd6, 4'd1), 3'b100, 4'd6, 1'b1, 1'b0, pl(21));
        #1;
        checks++;
        if (o_hz !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL unused_slot: hazard %b ready %b, expected 0 1", o_hz, o_rdy);
        end
        exp_q.push_back(pl(21));
        tick();
        idle();
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_pl !== pl(21)) begin
            errors++;
            $display("FAIL unused_issue: valid %b payload 0x%h, expected 1 0x%h", o_valid, o_pl, pl(21));
        end
        tick();
        $display("unused slot / dest done");
    endtask

    task automatic test_back_to_back_backpressure();
        sel_b = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, src3(4'd8, 4'd9, 4'd10), 3'b111, 4'd11, 1'b1, 1'b0, pl(40));
        exp_q.push_back(pl(40));
        tick();
        out_ready = 1'b0;
        drive(1'b1, src3(4'd1, 4'd1, 4'd1), 3'b111, 4'd12, 1'b1, 1'b0, pl(41));
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_rdy !== 1'b0 || o_pl !== pl(40)) begin
            errors++;
            $display("FAIL bp_block: valid %b ready %b payload 0x%h, expected 1 0 0x%h", o_valid, o_rdy, o_pl, pl(40));
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_rdy !== 1'b0 || o_pl !== pl(40) || o_dest !== 4'd11) begin
            errors++;
            $display("FAIL bp_hold: valid %b ready %b payload 0x%h dest %0d, expected 1 0 0x%h 11", o_valid, o_rdy, o_pl, o_dest, pl(40));
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ready %b, expected 1", o_rdy);
        end
        exp_q.push_back(pl(41));
        tick();
        idle();
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_pl !== pl(41)) begin
            errors++;
            $display("FAIL bp_next: valid %b payload 0x%h, expected 1 0x%h", o_valid, o_pl, pl(41));
        end
        tick();
        $display("backpressure done");
    endtask

    // Counts hazard cycles of a reader of r5 after a load of r5 on dut_b.
    task automatic test_lat3(input logic hold_two, input int exp_stalls, input logic [31:0] tag);
        int  stalls;
        logic done;
        sel_b = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, '0, 3'b000, 4'd5, 1'b1, 1'b1, pl(tag));
        exp_q.push_back(pl(tag));
        tick();
        drive(1'b1, src3(4'd5, 4'd0, 4'd0), 3'b001, 4'd2, 1'b1, 1'b0, pl(tag + 1));
        exp_q.push_back(pl(tag + 1));
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            out_ready = (hold_two && i < 2) ? 1'b0 : 1'b1;
            #1;
            if (hazard_b) begin
                stalls++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        checks++;
        if (!done || stalls != exp_stalls) begin
            errors++;
            $display("FAIL lat3_stalls: %0d stall cycles (ended %b), expected %0d", stalls, done, exp_stalls);
        end
        tick();
        idle();
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_pl !== pl(tag + 1)) begin
            errors++;
            $display("FAIL lat3_issue: valid %b payload 0x%h, expected 1 0x%h", o_valid, o_pl, pl(tag + 1));
        end
        tick();
        $display("lat3 reader after %0d stall cycles", stalls);
    endtask

    task automatic test_flush_load();
        sel_b = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, '0, 3'b000, 4'd2, 1'b1, 1'b1, pl(50));
        exp_q.push_back(pl(50));
        tick();
        idle();
        flush = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre: valid %b ready %b, expected 1 0", o_valid, o_rdy);
        end
        tick();
        flush = 1'b0;
        drive(1'b1, src3(4'd0, 4'd0, 4'd2), 3'b100, 4'd3, 1'b1, 1'b0, pl(51));
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_hz !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: valid %b hazard %b ready %b, expected 0 0 1", o_valid, o_hz, o_rdy);
        end
        exp_q.push_back(pl(51));
        tick();
        idle();
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_pl !== pl(51)) begin
            errors++;
            $display("FAIL flush_reader: valid %b payload 0x%h, expected 1 0x%h", o_valid, o_pl, pl(51));
        end
        tick();
        $display("flush of held load done");
    endtask

    task automatic test_flush_same_cycle();
        sel_b = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, '0, 3'b000, 4'd4, 1'b1, 1'b1, pl(60));
        exp_q.push_back(pl(60));
        tick();
        flush = 1'b1;
        drive(1'b1, '0, 3'b000, 4'd4, 1'b1, 1'b1, pl(61));
        #1;
        checks++;
        if (o_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_block: ready %b, expected 0", o_rdy);
        end
        tick();
        flush = 1'b0;
        drive(1'b1, src3(4'd4, 4'd0, 4'd0), 3'b001, 4'd1, 1'b0, 1'b0, pl(62));
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_hz !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_same: valid %b hazard %b ready %b, expected 0 0 1", o_valid, o_hz, o_rdy);
        end
        exp_q.push_back(pl(62));
        tick();
        idle();
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_pl !== pl(62) || out_dwe_b !== 1'b0) begin
            errors++;
            $display("FAIL flush_same_next: valid %b payload 0x%h we %b, expected 1 0x%h 0", o_valid, o_pl, out_dwe_b, pl(62));
        end
        tick();
        $display("same-cycle flush done");
    endtask

    task automatic test_reset_mid_stall();
        sel_b = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, '0, 3'b000, 4'd9, 1'b1, 1'b1, pl(70));
        exp_q.push_back(pl(70));
        tick();
        drive(1'b1, src3(4'd0, 4'd9, 4'd0), 3'b010, 4'd3, 1'b1, 1'b0, pl(71));
        #1;
        checks++;
        if (o_hz !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_pre: hazard %b, expected 1", o_hz);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (o_hz !== 1'b0 || o_valid !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_reset: hazard %b valid %b ready %b, expected 0 0 1", o_hz, o_valid, o_rdy);
        end
        exp_q.push_back(pl(71));
        tick();
        idle();
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_pl !== pl(71)) begin
            errors++;
            $display("FAIL mid_stall_issue: valid %b payload 0x%h, expected 1 0x%h", o_valid, o_pl, pl(71));
        end
        tick();
        $display("reset mid-stall done");
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall, exp_flush;
        do_reset();
        // 3 hazard cycles on dut_b, reader left valid in the output stage.
        sel_b = 1'b1;
        drive(1'b1, '0, 3'b000, 4'd5, 1'b1, 1'b1, pl(80));
        exp_q.push_back(pl(80));
        tick();
        drive(1'b1, src3(4'd5, 4'd5, 4'd5), 3'b111, 4'd6, 1'b1, 1'b0, pl(81));
        exp_q.push_back(pl(81));
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!hazard_b) break;
            @(posedge clk);
            #1;
        end
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, '0, 3'b000, 4'd7, 1'b1, 1'b0, pl(82));
        exp_q.push_back(pl(82));
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        // An extra flush with nothing held must not count.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
`ifdef DECODE_ISSUE_PERF_CNT_EN
        exp_stall = 32'd3;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        checks++;
        if (stall_b !== exp_stall || flushc_b !== exp_flush) begin
            errors++;
            $display("FAIL perf_counts: stall %0d flush %0d, expected %0d %0d", stall_b, flushc_b, exp_stall, exp_flush);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL perf_queue: %0d instructions unaccounted, expected 0", exp_q.size());
        end
        do_reset();
        #1;
        checks++;
        if (stall_b !== 32'd0 || flushc_b !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: stall %0d flush %0d, expected 0 0", stall_b, flushc_b);
        end
        $display("perf counters stall %0d flush %0d", stall_b, flushc_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        idle();
        test_reset();
        mon_en = 1'b1;
        test_load_use_lat1();
        test_unused_slot_and_dest();
        test_back_to_back_backpressure();
        test_lat3(1'b0, 3, 32'd30);
        test_lat3(1'b1, 5, 32'd32);
        test_flush_load();
        test_flush_same_cycle();
        test_reset_mid_stall();
        test_perf();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d instructions never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
